// File: rtl/subset_pkg.sv
// subset_pkg: mode codes, FSM states and distance-width helper shared by the raster scanner
package subset_pkg;
  localparam logic [2:0] MODE_A = 3'd0, MODE_AND = 3'd1, MODE_XOR = 3'd2, MODE_EXACT2 = 3'd3;
  localparam logic [2:0] MODE_ANY = 3'd4, MODE_ALL = 3'd5, MODE_PARITY = 3'd6, MODE_GE2 = 3'd7;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  function automatic int dist_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction
endpackage

// File: rtl/subset_point_eval.sv
// subset_point_eval: combinational per-circle inclusion test and subset selection for one grid point
module subset_point_eval
  import subset_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int NUM_CIRCLES = 3,
  parameter int RSQ_W       = 8
) (
  input  logic [COORD_W-1:0]               x_i,
  input  logic [COORD_W-1:0]               y_i,
  input  logic [NUM_CIRCLES*2*COORD_W-1:0] central_i,
  input  logic [NUM_CIRCLES*RSQ_W-1:0]     radius_square_i,
  input  logic [2:0]                       mode_i,
  output logic                             active_o
);
  localparam int DW = dist_w(COORD_W);
  localparam int MW = DW > RSQ_W ? DW : RSQ_W;
  localparam int PW = $clog2(NUM_CIRCLES + 1);
  logic [NUM_CIRCLES-1:0] inc;
  logic [PW-1:0] pop;
  logic exact2;
  for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_c
    logic [COORD_W-1:0] cx, cy, ax, ay;
    logic [DW-1:0] d;
    assign cx = central_i[(NUM_CIRCLES-1-i)*2*COORD_W+COORD_W +: COORD_W];
    assign cy = central_i[(NUM_CIRCLES-1-i)*2*COORD_W +: COORD_W];
    assign ax = cx >= x_i ? cx - x_i : x_i - cx;
    assign ay = cy >= y_i ? cy - y_i : y_i - cy;
    assign d = DW'(ax) * DW'(ax) + DW'(ay) * DW'(ay);
    assign inc[i] = MW'(d) <= MW'(radius_square_i[(NUM_CIRCLES-1-i)*RSQ_W +: RSQ_W]);
  end
  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_CIRCLES; k++) pop = pop + PW'(inc[k]);
  end
  assign exact2 = ((inc[0] & inc[1]) | (inc[1] & inc[2]) | (inc[0] & inc[2])) & ~(&inc[2:0]);
  assign active_o = mode_i == MODE_A      ? inc[0] :
                    mode_i == MODE_AND    ? inc[0] & inc[1] :
                    mode_i == MODE_XOR    ? inc[0] ^ inc[1] :
                    mode_i == MODE_EXACT2 ? exact2 :
                    mode_i == MODE_ANY    ? |inc :
                    mode_i == MODE_ALL    ? &inc :
                    mode_i == MODE_PARITY ? ^inc :
                                            pop >= PW'(2);
endmodule

// File: rtl/subset_raster_scanner.sv
// subset_raster_scanner: raster-scans the grid through a two-stage stallable pipeline, streaming subset membership and the active count
module subset_raster_scanner
  import subset_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int NUM_CIRCLES = 3,
  parameter int RSQ_W       = 8,
  parameter int CNT_W       = 2 * COORD_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_CIRCLES*2*COORD_W-1:0] central,
  input  logic [NUM_CIRCLES*RSQ_W-1:0]     radius_square,
  input  logic [2:0]                       mode,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [COORD_W-1:0]               pix_x,
  output logic [COORD_W-1:0]               pix_y,
  output logic                             pix_active,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 count
);
  state_t state_q, state_d;
  logic [NUM_CIRCLES*2*COORD_W-1:0] central_q;
  logic [NUM_CIRCLES*RSQ_W-1:0] rsq_q;
  logic [2:0] mode_q;
  logic [2*COORD_W-1:0] pos_q, s1_q;
  logic s1_v_q, adv, xfer, act;
  assign adv = !pix_valid || pix_ready;
  assign xfer = pix_valid && pix_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  subset_point_eval #(.COORD_W(COORD_W), .NUM_CIRCLES(NUM_CIRCLES), .RSQ_W(RSQ_W)) u_eval (
    .x_i(s1_q[COORD_W-1:0]),
    .y_i(s1_q[2*COORD_W-1:COORD_W]),
    .central_i(central_q),
    .radius_square_i(rsq_q),
    .mode_i(mode_q),
    .active_o(act)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (adv && &pos_q) state_d = DRAIN;
      DRAIN:   if (xfer && !s1_v_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      central_q <= '0;
      rsq_q <= '0;
      mode_q <= '0;
      pos_q <= '0;
      s1_q <= '0;
      s1_v_q <= 1'b0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_active <= 1'b0;
      count <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        central_q <= central;
        rsq_q <= radius_square;
        mode_q <= mode;
        pos_q <= '0;
        count <= '0;
      end
      if (adv) begin
        s1_v_q <= state_q == SCAN;
        s1_q <= pos_q;
        if (state_q == SCAN) pos_q <= pos_q + 1'b1;
        pix_valid <= s1_v_q;
        pix_x <= s1_q[COORD_W-1:0];
        pix_y <= s1_q[2*COORD_W-1:COORD_W];
        pix_active <= s1_v_q & act;
      end
      if (xfer && pix_active) count <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_subset_raster_scanner.sv
// tb_subset_raster_scanner: directed table-driven checks of the raster scanner plus stall, reset and restart sequences
module tb_subset_raster_scanner;
  localparam int CW = 4, N = 3, RW = 8, NW = 9;
  typedef struct {
    logic [N*2*CW-1:0] cen;
    logic [N*RW-1:0]   rsq;
    logic [2:0]        md;
    int                cnt;
    int                first;
  } vec_t;
  logic clk = 1'b0;
  logic rst, start, pix_ready, pix_valid, pix_active, busy, done;
  logic [N*2*CW-1:0] central;
  logic [N*RW-1:0] radius_square;
  logic [2:0] mode;
  logic [CW-1:0] pix_x, pix_y;
  logic [NW-1:0] count;
  int errors = 0, checks = 0;
  logic act_seq[256];
  logic ref_seq[256];
  vec_t vecs[15];
  always #5 clk = ~clk;
  subset_raster_scanner dut (
    .clk(clk), .rst(rst), .start(start), .central(central), .radius_square(radius_square),
    .mode(mode), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_active(pix_active), .busy(busy), .done(done), .count(count)
  );
  function automatic logic [7:0] pt(input int x, input int y);
    return {4'(x), 4'(y)};
  endfunction
  function automatic vec_t mk(input logic [23:0] c, input logic [23:0] r, input logic [2:0] m, input int n, input int f);
    vec_t v;
    v.cen = c; v.rsq = r; v.md = m; v.cnt = n; v.first = f;
    return v;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input bit tog, input bit poke, input string tag);
    int cyc, n, first, done_cyc, last_x, bad_order, bad_stall, act_cnt;
    logic stall_prev, pa_prev;
    logic [CW-1:0] px_prev, py_prev;
    n = 0; first = -1; done_cyc = -1; last_x = -1; bad_order = 0; bad_stall = 0; act_cnt = 0;
    stall_prev = 1'b0; pa_prev = 1'b0; px_prev = '0; py_prev = '0;
    @(negedge clk);
    central = v.cen; radius_square = v.rsq; mode = v.md; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000 && done_cyc < 0) begin
      if (poke && cyc == 50) begin
        start = 1'b1; central = ~v.cen; radius_square = ~v.rsq; mode = ~v.md;
      end
      if (poke && cyc == 51) start = 1'b0;
      pix_ready = tog ? cyc[0] : 1'b1;
      if (stall_prev && {pix_x, pix_y, pix_active, pix_valid} !== {px_prev, py_prev, pa_prev, 1'b1}) bad_stall++;
      if (done) begin
        done_cyc = cyc;
        chk({tag, " count at done"}, count, v.cnt);
        chk({tag, " busy at done"}, busy, 1);
      end
      if (pix_valid && pix_ready) begin
        if (pix_x !== 4'(n % 16) || pix_y !== 4'(n / 16)) bad_order++;
        if (pix_active) begin
          act_cnt++;
          if (first < 0) first = n;
        end
        if (n < 256) act_seq[n] = pix_active;
        n++;
        last_x = cyc;
      end
      stall_prev = pix_valid && !pix_ready;
      px_prev = pix_x; py_prev = pix_y; pa_prev = pix_active;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done cycle"}, done_cyc, tog ? last_x + 1 : 258);
    chk({tag, " transfers"}, n, 256);
    chk({tag, " raster order errs"}, bad_order, 0);
    chk({tag, " stall hold errs"}, bad_stall, 0);
    chk({tag, " active pixels"}, act_cnt, v.cnt);
    chk({tag, " first active"}, first, v.first);
    chk({tag, " done pulse width"}, done, 0);
    chk({tag, " busy after done"}, busy, 0);
    chk({tag, " count held"}, count, v.cnt);
  endtask
  initial begin
    int n, cyc, diff;
    logic dseen;
    vecs[0]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd0, 1, 136);
    vecs[1]  = mk({pt(0,0), pt(15,15), pt(15,15)}, {8'd200, 8'd0, 8'd0}, 3'd0, 173, 0);
    vecs[2]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd1, 1, 136);
    vecs[3]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd2, 0, -1);
    vecs[4]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd3, 1, 136);
    vecs[5]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd7, 1, 136);
    vecs[6]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd4, 2, 0);
    vecs[7]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd5, 0, -1);
    vecs[8]  = mk({pt(8,8), pt(8,8), pt(0,0)}, 24'd0, 3'd6, 1, 0);
    vecs[9]  = mk({pt(4,4), pt(4,4), pt(4,4)}, {8'd1, 8'd1, 8'd1}, 3'd5, 5, 52);
    vecs[10] = mk({pt(15,15), pt(0,0), pt(0,0)}, {8'd2, 8'd0, 8'd0}, 3'd0, 4, 238);
    vecs[11] = mk({pt(15,0), pt(0,0), pt(0,0)}, 24'd0, 3'd0, 1, 15);
    vecs[12] = mk({pt(4,4), pt(5,4), pt(0,0)}, {8'd1, 8'd1, 8'd0}, 3'd7, 2, 68);
    vecs[13] = mk({pt(4,4), pt(5,4), pt(0,0)}, {8'd1, 8'd1, 8'd0}, 3'd3, 2, 68);
    vecs[14] = mk({pt(4,4), pt(5,4), pt(0,0)}, {8'd1, 8'd1, 8'd0}, 3'd2, 6, 52);
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1; central = '0; radius_square = '0; mode = '0;
    repeat (3) @(negedge clk);
    chk("reset pix_valid", pix_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset count", count, 0);
    chk("reset pix_active", pix_active, 0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) run(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
    run(vecs[1], 1'b0, 1'b0, "trunc");
    chk("trunc (15,15)", act_seq[255], 0);
    chk("trunc (15,14)", act_seq[239], 0);
    chk("trunc (14,14)", act_seq[238], 0);
    chk("trunc (0,14)", act_seq[224], 1);
    chk("trunc (2,14) edge", act_seq[226], 1);
    chk("trunc (3,14)", act_seq[227], 0);
    for (int i = 0; i < 256; i++) ref_seq[i] = act_seq[i];
    run(vecs[1], 1'b1, 1'b0, "toggle");
    diff = 0;
    for (int i = 0; i < 256; i++) if (act_seq[i] !== ref_seq[i]) diff++;
    chk("toggle seq diffs", diff, 0);
    @(negedge clk);
    central = vecs[1].cen; radius_square = vecs[1].rsq; mode = vecs[1].md; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 100 && cyc < 1000) begin
      if (pix_valid && pix_ready) n++;
      if (n < 100) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("pre-reset transfers", n, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst pix_valid", pix_valid, 0);
    chk("midrst count", count, 0);
    chk("midrst done", done, 0);
    rst = 1'b0;
    dseen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      dseen |= done | busy | pix_valid;
    end
    chk("midrst no activity", dseen, 0);
    run(vecs[0], 1'b0, 1'b0, "post_rst");
    run(vecs[1], 1'b0, 1'b1, "poke");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/subset_raster_scanner.md
Name: subset_raster_scanner

Overview:
- Sequential, parametrised successor to the per-point circle-subset test.
- Owns its own raster scan of the full 2^COORD_W x 2^COORD_W grid against NUM_CIRCLES circles.
- Streams one activation bit per grid point over a valid/ready interface and reports the total active-point count.
- Sits between the config/register front end and the frame/display writer.

Parameters:
- COORD_W, 4, bits per x/y coordinate; grid is 2^COORD_W per side.
- NUM_CIRCLES, 3, number of circles, minimum 3.
- RSQ_W, 8, bits per radius-squared field.
- CNT_W, 2*COORD_W+1, width of the active-point counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- central  in  NUM_CIRCLES*2*COORD_W  circle centres; circle i at [(NUM_CIRCLES-1-i)*2*COORD_W +: 2*COORD_W], x in the upper COORD_W bits; circle 0 = A, 1 = B, 2 = C.
- radius_square  in  NUM_CIRCLES*RSQ_W  radius squared; circle i at [(NUM_CIRCLES-1-i)*RSQ_W +: RSQ_W].
- mode  in  3  selection rule (see Behaviour).
- pix_valid  out  1  pix_x/pix_y/pix_active are valid.
- pix_ready  in  1  downstream accepts the current pixel.
- pix_x  out  COORD_W  pixel x.
- pix_y  out  COORD_W  pixel y.
- pix_active  out  1  pixel is in the selected subset.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last pixel handshake.
- count  out  CNT_W  active pixels accepted in the current/last scan.

Behaviour:
- Reset: all outputs 0, count 0, FSM to IDLE. Applies from any state, including mid-scan; no partial done pulse.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN: on start. central, radius_square and mode are latched that cycle; count cleared; input changes after that have no effect until the next start. start while not in IDLE is ignored.
- Scan order: y outer, x inner, from (0,0) to (2^COORD_W-1, 2^COORD_W-1); x wraps to 0 and y increments.
- Pipeline, two stages:
  - S1: coordinate register.
  - S2: per-circle include vector plus mode result, registered onto the pix_* outputs.
  - First pix_valid is 2 cycles after the start-accept cycle.
- SCAN -> DRAIN: the cycle the last coordinate enters S1.
- DRAIN -> DONE: on handshake of the last pixel.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy: high from the cycle after start through the DONE cycle.
- Handshake: a pixel transfers when pix_valid && pix_ready. While pix_valid && !pix_ready, the whole pipeline stalls and pix_* hold stable. pix_valid never drops without a transfer.
- Per circle:
  - d = |cx - x|^2 + |cy - y|^2, computed at 2*COORD_W+1 bits with no truncation.
  - include = (d <= zero-extended radius_square).
- Mode encoding:
  - 0: A.
  - 1: A & B.
  - 2: A ^ B.
  - 3: exactly two of A, B, C.
  - 4: OR over all circles.
  - 5: AND over all circles.
  - 6: XOR parity over all circles.
  - 7: at least two circles included.
- count increments on each transferred pixel with pix_active = 1. It holds its final value from the DONE cycle until the next start. Max value 2^(2*COORD_W) fits CNT_W.
- Throughput with pix_ready tied high: one pixel per cycle. With the defaults, done is asserted at cycle 258 relative to start-accept at cycle 0.

Decomposition:
- Package subset_pkg holds:
  - mode encodings (MODE_A, MODE_AND, MODE_XOR, MODE_EXACT2, MODE_ANY, MODE_ALL, MODE_PARITY, MODE_GE2);
  - FSM state encoding;
  - a function returning the distance width from COORD_W.
- One sub-module, subset_point_eval: combinational. Inputs are x, y, latched centres, latched radii and mode. Output is the activation bit. Instantiated once, in front of the S2 register.

Test Plan:
- Mode 0, A = (8,8), rsq_A = 0, pix_ready = 1 -> exactly one pix_active = 1, at (8,8); count = 1; done at cycle 258; 256 pix_valid cycles in raster order.
- Mode 0, A = (0,0), rsq_A = 200 -> pix_active = 0 at (15,15) (d = 450) and at (15,14) (d = 421); checks no distance truncation.
- Three radius-0 circles, A = B = (8,8), C = (0,0):
  - mode 1 -> count 1;
  - mode 2 -> count 0;
  - mode 3 -> count 1;
  - mode 7 -> count 1;
  - mode 4 -> count 2.
- pix_ready toggling every other cycle, any mode -> pix_* stable during stalls; identical pixel sequence and count to the pix_ready = 1 run; done one cycle after the final handshake.
- rst asserted after the 100th transfer -> next cycle busy = 0, pix_valid = 0, count = 0, no done pulse; a new start then completes a full 256-pixel scan.
- start pulsed and config changed mid-scan -> ignored; the scan result matches the config latched at the original start.
